board_answer_checker: RTL and testbench
=======================================

// Module: board_answer_checker
// PURPOSE
//  Consumer side of the Memory Matrix board: takes the 8-cell board from the
//  generator, shows it for a fixed time, hides it, then accepts player guesses
//  one cell at a time and judges them. Drives the cell display, lives, round
//  result and running score for the top-level game FSM and LED/HEX drivers.
// PARAMETERS
//  SHOW_CYCLES   50000000  clocks the board is displayed before hiding (>=1)
//  MAX_LIVES     3         wrong guesses allowed per round (1..3)
//  SCORE_W       8         score width; score saturates at 2^SCORE_W-1
//  INPUT_CYCLES  500000000 input-phase time limit (used only with INPUT_TIMEOUT_EN)
// PORTS
//  clk           in   1        clock, all logic on posedge
//  reset         in   1        synchronous, active-low
//  board         in   8        target pattern, bit i = cell i lit
//  board_valid   in   1        1-cycle strobe: board holds a new pattern
//  guess_idx     in   3        cell being guessed
//  guess_strobe  in   1        guess key level (already synchronised), high = pressed
//  display       out  8        cells to light
//  revealed      out  8        correctly guessed cells this round
//  misses        out  8        wrongly guessed cells this round
//  lives         out  2        remaining lives
//  win           out  1        high while in WIN
//  lose          out  1        high while in LOSE
//  round_done    out  1        1-cycle pulse on entry to WIN or LOSE
//  score         out  SCORE_W  rounds won since last loss
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; target, counters, key history 0.
//  - States IDLE, SHOW, INPUT, WIN, LOSE. display: IDLE 0; SHOW target;
//    INPUT revealed; WIN/LOSE target. win/lose/display from registered state.
//  - IDLE/WIN/LOSE: board_valid && board!=0 -> latch target=board,
//    revealed=0, misses=0, lives=MAX_LIVES, counter=SHOW_CYCLES-1, go SHOW.
//    board_valid with board==0 ignored. board_valid in SHOW/INPUT ignored.
//  - SHOW: counter decrements each clock; at 0 -> INPUT (target shown exactly
//    SHOW_CYCLES clocks). Guesses ignored.
//  - Key history register updates every cycle in every state; a guess is a
//    0->1 transition of guess_strobe sampled in INPUT. Key held on entry to
//    INPUT gives no guess. One guess per press regardless of hold length.
//  - Guess, idx=i, result visible one clock after first high sample:
//    target[i] & !revealed[i]: set revealed[i]; if new revealed==target -> WIN.
//    target[i] & revealed[i]: no effect.
//    !target[i] & !misses[i]: set misses[i], lives-1; if lives was 1 -> LOSE.
//    !target[i] & misses[i]: no effect (no repeated penalty).
//  - WIN entry: score+1, saturating at all-ones. LOSE entry: score=0.
//  - round_done high exactly the first cycle of WIN or LOSE.
//  - WIN/LOSE held (revealed, misses, lives frozen) until next valid board.
//  - Reset low in any state: IDLE and all outputs 0 after that edge.
// CONFIGURATION
//  - INPUT_TIMEOUT_EN defined: counter loaded INPUT_CYCLES-1 on entry to
//    INPUT, decrements each clock, not reloaded by guesses; expiry in INPUT ->
//    LOSE (same entry actions). A guess completing the board in the expiry
//    cycle wins (guess has priority).
//  - Not defined: no timeout, INPUT waits indefinitely; INPUT_CYCLES unused.
// TESTING (SHOW_CYCLES=4, MAX_LIVES=3, INPUT_CYCLES=20 overrides)
//  - Reset low 2 clocks -> display/revealed/misses/lives/win/lose/score = 0.
//  - board=8'h05 + board_valid -> display=8'h05 for 4 clocks, then 8'h00;
//    guess 0 -> revealed=8'h01; guess 2 -> revealed=8'h05, win=1,
//    round_done single pulse, score=1.
//  - board=8'h05; guesses 1,1,3,4 -> misses 8'h02 lives 2; repeat 1 no change;
//    misses 8'h0A lives 1; lives 0, lose=1, score=0, display=8'h05.
//  - guess_strobe held 10 clocks at idx 0 -> one guess only; press during SHOW
//    and still held into INPUT -> no guess.
//  - board_valid with board=0 in IDLE -> stays IDLE; new board_valid in INPUT
//    -> ignored; reset low mid-INPUT -> IDLE, outputs 0.
//  - INPUT_TIMEOUT_EN: no guesses for 20 clocks in INPUT -> lose=1, round_done
//    pulse; without macro, 100 idle clocks -> still INPUT.

Source files
------------

// File: rtl/board_answer_checker.sv
// Memory Matrix answer checker: latches a board, shows it for SHOW_CYCLES, then judges
// one-cell guesses. Optional input-phase timeout is enabled with `define INPUT_TIMEOUT_EN.
module board_answer_checker #(
    parameter int unsigned SHOW_CYCLES  = 50000000,
    parameter int unsigned MAX_LIVES    = 3,
    parameter int unsigned SCORE_W      = 8,
    parameter int unsigned INPUT_CYCLES = 500000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         board,
    input  logic               board_valid,
    input  logic [2:0]         guess_idx,
    input  logic               guess_strobe,
    output logic [7:0]         display,
    output logic [7:0]         revealed,
    output logic [7:0]         misses,
    output logic [1:0]         lives,
    output logic               win,
    output logic               lose,
    output logic               round_done,
    output logic [SCORE_W-1:0] score
);

    // One shared down-counter serves both the show phase and the input timeout.
    localparam int unsigned CNT_MAX = (SHOW_CYCLES > INPUT_CYCLES) ? SHOW_CYCLES : INPUT_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHOW  = 3'd1,
        ST_INPUT = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         target_q, target_d;
    logic [7:0]         revealed_q, revealed_d;
    logic [7:0]         misses_q, misses_d;
    logic [1:0]         lives_q, lives_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               key_q, key_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [7:0]         display_q, display_d;
    logic               win_q, win_d;
    logic               lose_q, lose_d;
    logic               round_done_q, round_done_d;

    logic       press;
    logic       go_win;
    logic       go_lose;
    logic [7:0] idx_bit;

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        revealed_d   = revealed_q;
        misses_d     = misses_q;
        lives_d      = lives_q;
        cnt_d        = cnt_q;
        score_d      = score_q;
        round_done_d = 1'b0;
        key_d        = guess_strobe;
        go_win       = 1'b0;
        go_lose      = 1'b0;
        display_d    = '0;
        press        = guess_strobe && !key_q;
        idx_bit      = 8'd1 << guess_idx;

        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (board_valid && (board != 8'd0)) begin
                    state_d    = ST_SHOW;
                    target_d   = board;
                    revealed_d = '0;
                    misses_d   = '0;
                    lives_d    = 2'(MAX_LIVES);
                    cnt_d      = CNT_W'(SHOW_CYCLES - 1);
                end
            end
            ST_SHOW: begin
                if (cnt_q == '0) begin
                    state_d = ST_INPUT;
`ifdef INPUT_TIMEOUT_EN
                    cnt_d   = CNT_W'(INPUT_CYCLES - 1);
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_INPUT: begin
                if (press) begin
                    if (target_q[guess_idx]) begin
                        if (!revealed_q[guess_idx]) begin
                            revealed_d = revealed_q | idx_bit;
                            go_win     = ((revealed_q | idx_bit) == target_q);
                        end
                    end else if (!misses_q[guess_idx]) begin
                        misses_d = misses_q | idx_bit;
                        lives_d  = lives_q - 2'd1;
                        go_lose  = (lives_q == 2'd1);
                    end
                end
`ifdef INPUT_TIMEOUT_EN
                // A completing guess in the expiry cycle still wins.
                if (!go_win && !go_lose) begin
                    if (cnt_q == '0) begin
                        go_lose = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
`endif
                if (go_win) begin
                    state_d      = ST_WIN;
                    round_done_d = 1'b1;
                    score_d      = (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + SCORE_W'(1);
                end else if (go_lose) begin
                    state_d      = ST_LOSE;
                    round_done_d = 1'b1;
                    score_d      = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_SHOW:          display_d = target_d;
            ST_INPUT:         display_d = revealed_d;
            ST_WIN, ST_LOSE:  display_d = target_d;
            default:          display_d = '0;
        endcase
        win_d  = (state_d == ST_WIN);
        lose_d = (state_d == ST_LOSE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            target_q     <= '0;
            revealed_q   <= '0;
            misses_q     <= '0;
            lives_q      <= '0;
            cnt_q        <= '0;
            key_q        <= 1'b0;
            score_q      <= '0;
            display_q    <= '0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
            round_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            revealed_q   <= revealed_d;
            misses_q     <= misses_d;
            lives_q      <= lives_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            score_q      <= score_d;
            display_q    <= display_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
            round_done_q <= round_done_d;
        end
    end

    assign display    = display_q;
    assign revealed   = revealed_q;
    assign misses     = misses_q;
    assign lives      = lives_q;
    assign win        = win_q;
    assign lose       = lose_q;
    assign round_done = round_done_q;
    assign score      = score_q;

endmodule

// File: tb/tb_board_answer_checker.sv
// Bench for board_answer_checker: directed game scenarios plus random play, every cycle
// checked against a round-level game model. Honors `define INPUT_TIMEOUT_EN.
module tb_board_answer_checker;

    localparam int unsigned SHOW   = 4;
    localparam int unsigned LIVES  = 3;
    localparam int unsigned SW     = 8;
    localparam int unsigned INCYC  = 20;

    localparam int P_IDLE  = 0;
    localparam int P_SHOW  = 1;
    localparam int P_INPUT = 2;
    localparam int P_WIN   = 3;
    localparam int P_LOSE  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    board;
    logic          board_valid;
    logic [2:0]    guess_idx;
    logic          guess_strobe;
    logic [7:0]    display;
    logic [7:0]    revealed;
    logic [7:0]    misses;
    logic [1:0]    lives;
    logic          win;
    logic          lose;
    logic          round_done;
    logic [SW-1:0] score;

    board_answer_checker #(
        .SHOW_CYCLES (SHOW),
        .MAX_LIVES   (LIVES),
        .SCORE_W     (SW),
        .INPUT_CYCLES(INCYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .board       (board),
        .board_valid (board_valid),
        .guess_idx   (guess_idx),
        .guess_strobe(guess_strobe),
        .display     (display),
        .revealed    (revealed),
        .misses      (misses),
        .lives       (lives),
        .win         (win),
        .lose        (lose),
        .round_done  (round_done),
        .score       (score)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Game model state
    int         m_phase = P_IDLE;
    logic [7:0] m_target = '0;
    logic [7:0] m_rev = '0;
    logic [7:0] m_mis = '0;
    int         m_lives = 0;
    int         m_score = 0;
    int         m_show_left = 0;
    int         m_in_edges = 0;
    bit         m_key = 1'b0;
    bit         m_rd = 1'b0;
    bit         timeout_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_finish(input bit won);
        m_rd = 1'b1;
        if (won) begin
            m_phase = P_WIN;
            m_score = (m_score == 255) ? 255 : m_score + 1;
        end else begin
            m_phase = P_LOSE;
            m_score = 0;
        end
    endtask

    // Advance the model by the upcoming clock edge using the inputs now applied.
    task automatic model_edge();
        bit         press_now;
        logic [7:0] b;
        m_rd = 1'b0;
        if (!reset) begin
            m_phase = P_IDLE; m_target = '0; m_rev = '0; m_mis = '0;
            m_lives = 0; m_score = 0; m_key = 1'b0;
            return;
        end
        press_now = guess_strobe && !m_key;
        m_key = guess_strobe;
        if (m_phase == P_IDLE || m_phase == P_WIN || m_phase == P_LOSE) begin
            if (board_valid && board != 8'd0) begin
                m_phase = P_SHOW; m_target = board; m_rev = '0; m_mis = '0;
                m_lives = LIVES; m_show_left = SHOW;
            end
        end else if (m_phase == P_SHOW) begin
            m_show_left--;
            if (m_show_left == 0) begin
                m_phase = P_INPUT;
                m_in_edges = 0;
            end
        end else begin
            m_in_edges++;
            if (press_now) begin
                b = 8'd1 << guess_idx;
                if ((m_target & b) != 0) m_rev = m_rev | b;
                else if ((m_mis & b) == 0) begin
                    m_mis = m_mis | b;
                    m_lives--;
                end
                if (m_rev == m_target) model_finish(1'b1);
                else if (m_lives == 0) model_finish(1'b0);
            end
            if (timeout_en && m_phase == P_INPUT && m_in_edges == INCYC) model_finish(1'b0);
        end
    endtask

    task automatic check_all();
        logic [7:0] exp_disp;
        case (m_phase)
            P_SHOW:  exp_disp = m_target;
            P_INPUT: exp_disp = m_rev;
            P_WIN, P_LOSE: exp_disp = m_target;
            default: exp_disp = '0;
        endcase
        check("display",    32'(display),    32'(exp_disp));
        check("revealed",   32'(revealed),   32'(m_rev));
        check("misses",     32'(misses),     32'(m_mis));
        check("lives",      32'(lives),      32'(m_lives));
        check("win",        32'(win),        32'(m_phase == P_WIN));
        check("lose",       32'(lose),       32'(m_phase == P_LOSE));
        check("round_done", 32'(round_done), 32'(m_rd));
        check("score",      32'(score),      32'(m_score));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wait_n(input int n);
        repeat (n) step();
    endtask

    task automatic load(input logic [7:0] b);
        board = b; board_valid = 1'b1;
        step();
        board_valid = 1'b0;
    endtask

    task automatic press(input int idx, input int hold);
        guess_idx = 3'(idx); guess_strobe = 1'b1;
        repeat (hold) step();
        guess_strobe = 1'b0;
        step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        wait_n(2);
        reset = 1'b1;
    endtask

    initial begin
`ifdef INPUT_TIMEOUT_EN
        timeout_en = 1'b1;
`else
        timeout_en = 1'b0;
`endif
        reset = 1'b0; board = '0; board_valid = 1'b0; guess_idx = '0; guess_strobe = 1'b0;
        #1;
        do_reset();
        check("rst_display", 32'(display), 32'h0);
        check("rst_lives",   32'(lives),   32'h0);

        // Winning round
        load(8'h05);
        check("show_disp", 32'(display), 32'h05);
        wait_n(4);
        check("hidden_disp", 32'(display), 32'h00);
        press(0, 1);
        check("rev_after_0", 32'(revealed), 32'h01);
        guess_idx = 3'd2; guess_strobe = 1'b1;
        step();
        check("win_pulse", 32'(round_done), 32'h1);
        guess_strobe = 1'b0;
        step();
        check("win_pulse_end", 32'(round_done), 32'h0);
        check("win_flag", 32'(win), 32'h1);
        check("win_score", 32'(score), 32'h1);

        // Losing round with a repeated miss
        load(8'h05);
        wait_n(4);
        press(1, 1);
        check("miss1", 32'(misses), 32'h02);
        check("lives2", 32'(lives), 32'h2);
        press(1, 1);
        check("miss_repeat", 32'(lives), 32'h2);
        press(3, 1);
        check("miss2", 32'(misses), 32'h0A);
        check("lives1", 32'(lives), 32'h1);
        press(4, 1);
        check("lives0", 32'(lives), 32'h0);
        check("lose_flag", 32'(lose), 32'h1);
        check("lose_score", 32'(score), 32'h0);
        check("lose_disp", 32'(display), 32'h05);

        // Key held from SHOW into INPUT, then a long press, then board_valid in INPUT
        load(8'h05);
        guess_idx = 3'd0; guess_strobe = 1'b1;
        wait_n(6);
        guess_strobe = 1'b0;
        step();
        check("held_no_guess", 32'(revealed), 32'h00);
        press(0, 10);
        check("long_press", 32'(revealed), 32'h01);
        load(8'hFF);
        check("valid_in_input", 32'(display), 32'h01);

        // Zero board in IDLE, reset mid-INPUT
        do_reset();
        load(8'h00);
        wait_n(2);
        check("zero_board", 32'(display), 32'h00);
        load(8'h05);
        wait_n(4);
        press(0, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("mid_reset_rev", 32'(revealed), 32'h00);
        check("mid_reset_disp", 32'(display), 32'h00);

        // Idle input phase
        load(8'h05);
        wait_n(4);
        if (timeout_en) begin
            wait_n(19);
            check("pre_timeout", 32'(lose), 32'h0);
            step();
            check("timeout_lose", 32'(lose), 32'h1);
            check("timeout_pulse", 32'(round_done), 32'h1);
        end else begin
            wait_n(100);
            check("no_timeout_lose", 32'(lose), 32'h0);
            check("no_timeout_disp", 32'(display), 32'h00);
        end

        // Random play
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 199) != 0);
            board_valid = ($urandom_range(0, 19) == 0);
            board = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                guess_strobe = !guess_strobe;
                if (guess_strobe) guess_idx = 3'($urandom_range(0, 7));
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
